// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
//
// Produces a registered, single-cycle tick on clkOUT once every VALUE rising
// edges of clkIN. The tick is meant to be used as a clock enable, not as a
// clock. The first tick follows edge VALUE after reset release, so reset
// release fixes the tick phase. Pulsing resetIN restarts that phase.
//
// Parameters
//   VALUE      divide ratio, 1 .. 2^24-1 (default 2)
//
// Ports
//   clkIN      in   system clock; all state updates on its rising edge
//   resetIN    in   asynchronous, active-high reset. Deassertion must already
//                   be synchronous to clkIN, because no synchronizer is added.
//   clkOUT     out  one-cycle tick after edges VALUE, 2*VALUE, ...
//   toggleOUT  out  square wave with a period of 2*VALUE cycles. It inverts on
//                   every tick edge.
//
// Optional feature
//   Define CLOCK_DIVIDER_TOGGLE_OUT_EN to add the toggleOUT port and its flop.
//   The clkOUT behaviour is identical with or without the macro.
// -----------------------------------------------------------------------------
module clock_divider #(
  parameter int VALUE = 2
) (
  input  logic clkIN,
  input  logic resetIN,
`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
  output logic toggleOUT,
`endif
  output logic clkOUT
);

  // A 1-bit counter is kept for VALUE == 1 so that the type stays legal.
  // In that case the counter never leaves 0.
  localparam int CW = (VALUE > 1) ? $clog2(VALUE) : 1;
  localparam logic [CW-1:0] LAST = CW'(VALUE - 1);

  if (VALUE < 1 || VALUE > 24'hFF_FFFF) begin : g_bad_value
    $error("clock_divider: VALUE=%0d outside legal range 1..2^24-1", VALUE);
  end

  logic [CW-1:0] count_q, count_d;
  logic          clk_out_q, clk_out_d;
  logic          wrap;

  // A tick is issued on the same edge that wraps the counter. This keeps the
  // spacing at exactly VALUE cycles, with no extra cycle spent on the wrap.
  assign wrap = (count_q == LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    count_d   = count_q + CW'(1);
    clk_out_d = 1'b0;
    if (wrap) begin
      count_d   = '0;
      clk_out_d = 1'b1;
    end
  end

  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) begin
      count_q   <= '0;
      clk_out_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // sample their pre-edge values and there are no ordering races.
      count_q   <= count_d;
      clk_out_q <= clk_out_d;
    end
  end

  // clkOUT comes straight from a flop. It has no combinational path from any
  // input, so it cannot glitch.
  assign clkOUT = clk_out_q;

`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
  logic toggle_q;

  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) toggle_q <= 1'b0;
    else         toggle_q <= toggle_q ^ wrap;
  end

  assign toggleOUT = toggle_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_clock_divider
//
// Directed bench for clock_divider. It instantiates the divider with VALUE
// set to 4, 14, 1 and 3. Each instance has its own reset, so each scenario
// starts from a clean release. Expected values come from the tick rule: the
// tick is high after edge e exactly when e % VALUE == 0, where e counts from
// the first edge after release. When the macro is defined, the toggle after
// edge e equals (e / VALUE) % 2.
// -----------------------------------------------------------------------------
module tb_clock_divider;

  logic clk = 1'b0;
  logic rst4, rst14, rst1, rst3;
  logic out4, out14, out1, out3;
`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
  logic tog4, tog14, tog1, tog3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_divider #(.VALUE(4)) u_div4 (
    .clkIN(clk), .resetIN(rst4),
`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
    .toggleOUT(tog4),
`endif
    .clkOUT(out4)
  );

  clock_divider #(.VALUE(14)) u_div14 (
    .clkIN(clk), .resetIN(rst14),
`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
    .toggleOUT(tog14),
`endif
    .clkOUT(out14)
  );

  clock_divider #(.VALUE(1)) u_div1 (
    .clkIN(clk), .resetIN(rst1),
`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
    .toggleOUT(tog1),
`endif
    .clkOUT(out1)
  );

  clock_divider #(.VALUE(3)) u_div3 (
    .clkIN(clk), .resetIN(rst3),
`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
    .toggleOUT(tog3),
`endif
    .clkOUT(out3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then sample just after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int last_pulse;

    rst4 = 1'b1; rst14 = 1'b1; rst1 = 1'b1; rst3 = 1'b1;
    tick();
    tick();

    // All outputs are held low while reset is high, even with the clock running.
    check("rst_v4",  32'(out4),  0);
    check("rst_v14", 32'(out14), 0);
    check("rst_v1",  32'(out1),  0);
    check("rst_v3",  32'(out3),  0);
`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
    check("rst_tog3", 32'(tog3), 0);
`endif

    // VALUE=4: ticks after edges 4, 8 and 12 only.
    @(negedge clk) rst4 = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      check($sformatf("v4_run_e%0d", e), 32'(out4), 32'(e % 4 == 0));
    end

    // VALUE=4: a short reset pulse mid-count, between edges 2 and 3.
    // The next tick must follow the 4th edge after this pulse.
    @(negedge clk) rst4 = 1'b1;
    @(negedge clk) rst4 = 1'b0;
    tick(); check("v4_pre_e1", 32'(out4), 0);
    tick(); check("v4_pre_e2", 32'(out4), 0);
    #1 rst4 = 1'b1;
    #2 rst4 = 1'b0;   // the pulse is much shorter than one clock period
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("v4_short_rst_e%0d", e), 32'(out4), 32'(e % 4 == 0));
    end

    // VALUE=4: reset asserted while clkOUT is high. The tick falls at once,
    // before any further clock edge.
    check("v4_high_before_rst", 32'(out4), 1);
    #1 rst4 = 1'b1;
    #1 check("v4_async_fall", 32'(out4), 0);
    @(negedge clk) rst4 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("v4_after_high_rst_e%0d", e), 32'(out4), 32'(e % 4 == 0));
    end

    // VALUE=14 over 200 edges: 14 ticks, each spaced exactly 14 edges apart.
    pulses     = 0;
    last_pulse = 0;
    @(negedge clk) rst14 = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      check($sformatf("v14_e%0d", e), 32'(out14), 32'(e % 14 == 0));
      if (out14) begin
        if (last_pulse != 0)
          check($sformatf("v14_spacing_e%0d", e), 32'(e - last_pulse), 14);
        last_pulse = e;
        pulses++;
      end
    end
    check("v14_pulse_count", 32'(pulses), 14);

    // VALUE=1: clkOUT is high continuously from edge 1 onward, and drops
    // asynchronously when reset is asserted.
    @(negedge clk) rst1 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("v1_e%0d", e), 32'(out1), 1);
    end
    #1 rst1 = 1'b1;
    #1 check("v1_async_fall", 32'(out1), 0);

    // VALUE=3: ticks after edges 3, 6 and 9. When present, the toggle output
    // reads 1 after edge 3, 0 after edge 6 and 1 after edge 9.
    @(negedge clk) rst3 = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check($sformatf("v3_e%0d", e), 32'(out3), 32'(e % 3 == 0));
`ifdef CLOCK_DIVIDER_TOGGLE_OUT_EN
      check($sformatf("v3_tog_e%0d", e), 32'(tog3), 32'((e / 3) % 2));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
